// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage: PC register, sequential next-PC adder, branch/jump
// redirect, stall/flush hazard control and the IF/ID pipeline register with a
// valid bit. Also keeps a sticky misaligned-redirect flag and a counter of
// valid instructions handed to decode.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   imem_addr        out  instruction-memory address (combinationally the PC)
//   imem_data        in   instruction returned combinationally for imem_addr
//   stall            in   hold PC and IF/ID
//   flush            in   squash IF/ID into a bubble
//   redirect         in   taken branch/jump this cycle
//   redirect_target  in   new PC when redirect is high
//   instruction_out  out  IF/ID instruction
//   inst_addr_out    out  IF/ID instruction address
//   valid_out        out  IF/ID holds a real instruction
//   misalign_err     out  sticky misaligned-redirect flag
//   fetch_count      out  number of valid instructions latched into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    INST_WIDTH = 32,
   parameter int                    INST_BYTES = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013),
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [INST_WIDTH-1:0] imem_data,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [INST_WIDTH-1:0] instruction_out,
   output logic [ADDR_WIDTH-1:0] inst_addr_out,
   output logic                  valid_out,
   output logic                  misalign_err,
   output logic [CNT_WIDTH-1:0]  fetch_count
);

   // Low-order byte-offset bits inside one instruction; a mask of zero
   // (INST_BYTES = 1) makes every target aligned.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [INST_WIDTH-1:0] r_inst;
   logic [ADDR_WIDTH-1:0] r_inst_addr;
   logic                  r_valid;
   logic                  r_misalign;
   logic [CNT_WIDTH-1:0]  r_count;

   logic [ADDR_WIDTH-1:0] w_target_aligned;
   logic                  w_target_misaligned;
   logic                  w_bubble;
   logic                  w_load;

   always_comb begin
      w_target_aligned    = redirect_target & ~ALIGN_MASK;
      w_target_misaligned = |(redirect_target & ALIGN_MASK);
      // A redirect squashes the instruction fetched down the wrong path,
      // even when decode is stalled.
      w_bubble            = redirect | flush;
      w_load              = !w_bubble && !stall;
   end

   // ---- PC stage ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= w_target_aligned;
      end else if (!stall) begin
         r_pc <= r_pc + PC_STEP;
      end
   end

   // ---- IF/ID boundary ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst      <= NOP_INST;
         r_inst_addr <= '0;
         r_valid     <= 1'b0;
      end else if (w_bubble) begin
         r_inst      <= NOP_INST;
         r_inst_addr <= '0;
         r_valid     <= 1'b0;
      end else if (!stall) begin
         r_inst      <= imem_data;
         r_inst_addr <= r_pc;
         r_valid     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalign <= 1'b0;
         r_count    <= '0;
      end else begin
         if (redirect && w_target_misaligned) begin
            r_misalign <= 1'b1;
         end
         if (w_load) begin
            r_count <= r_count + CNT_WIDTH'(1);
         end
      end
   end

   assign imem_addr       = r_pc;
   assign instruction_out = r_inst;
   assign inst_addr_out   = r_inst_addr;
   assign valid_out       = r_valid;
   assign misalign_err    = r_misalign;
   assign fetch_count     = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam int                ADDR_WIDTH = 64;
   localparam int                INST_WIDTH = 32;
   localparam int                CNT_WIDTH  = 4;
   localparam logic [63:0]       RESET_PC   = 64'h1000;
   localparam logic [31:0]       NOP        = 32'h0000_0013;

   logic                  clk;
   logic                  reset;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [INST_WIDTH-1:0] imem_data;
   logic                  stall;
   logic                  flush;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic [INST_WIDTH-1:0] instruction_out;
   logic [ADDR_WIDTH-1:0] inst_addr_out;
   logic                  valid_out;
   logic                  misalign_err;
   logic [CNT_WIDTH-1:0]  fetch_count;

   fetch_stage #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH),
      .INST_BYTES (4),
      .RESET_PC   (RESET_PC),
      .NOP_INST   (NOP),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .stall           (stall),
      .flush           (flush),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .instruction_out (instruction_out),
      .inst_addr_out   (inst_addr_out),
      .valid_out       (valid_out),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: contents derived from the address so each fetched
   // word identifies where it came from.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   always_comb imem_data = mem_word(imem_addr);

   typedef struct {
      logic        v;
      logic [63:0] addr;
      logic [63:0] pc;
      logic        mis;
      logic [3:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the expected response for each edge and compares it with
   // what the DUT presents half a cycle later.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("valid_out",       64'(valid_out),       64'(e.v));
            check("inst_addr_out",   inst_addr_out,        e.addr);
            check("instruction_out", 64'(instruction_out), 64'(e.v ? mem_word(e.addr) : NOP));
            check("pc",              imem_addr,            e.pc);
            check("misalign_err",    64'(misalign_err),    64'(e.mis));
            check("fetch_count",     64'(fetch_count),     64'(e.cnt));
         end
      end
   end

   // Drive one cycle of inputs, let the edge happen, then queue the
   // hand-computed state expected after that edge.
   task automatic step(input logic rs, input logic st, input logic fl, input logic rd,
                       input logic [63:0] tgt, input logic ev, input logic [63:0] ea,
                       input logic [63:0] epc, input logic em, input logic [3:0] ec);
      exp_t e;
      reset           = rs;
      stall           = st;
      flush           = fl;
      redirect        = rd;
      redirect_target = tgt;
      @(posedge clk);
      #1;
      e.v = ev; e.addr = ea; e.pc = epc; e.mis = em; e.cnt = ec;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = '0;

      // Reset held for two edges
      step(1,0,0,0,0,        0, 64'h0,    64'h1000, 0, 4'd0);
      step(1,0,0,0,0,        0, 64'h0,    64'h1000, 0, 4'd0);
      // Sequential run from the reset vector
      step(0,0,0,0,0,        1, 64'h1000, 64'h1004, 0, 4'd1);
      step(0,0,0,0,0,        1, 64'h1004, 64'h1008, 0, 4'd2);
      step(0,0,0,0,0,        1, 64'h1008, 64'h100C, 0, 4'd3);
      // Stall for three cycles: everything frozen
      step(0,1,0,0,0,        1, 64'h1008, 64'h100C, 0, 4'd3);
      step(0,1,0,0,0,        1, 64'h1008, 64'h100C, 0, 4'd3);
      step(0,1,0,0,0,        1, 64'h1008, 64'h100C, 0, 4'd3);
      step(0,0,0,0,0,        1, 64'h100C, 64'h1010, 0, 4'd4);
      // Aligned redirect: bubble, then target instruction
      step(0,0,0,1,64'h2000, 0, 64'h0,    64'h2000, 0, 4'd4);
      step(0,0,0,0,0,        1, 64'h2000, 64'h2004, 0, 4'd5);
      // Redirect during stall to a misaligned target
      step(0,1,0,1,64'h3002, 0, 64'h0,    64'h3000, 1, 4'd5);
      for (int k = 1; k <= 10; k++)
         step(0,0,0,0,0, 1, 64'h3000 + 64'(4*(k-1)), 64'h3000 + 64'(4*k), 1, 4'(5+k));
      // Flush together with stall: bubble, PC and count hold
      step(0,1,1,0,0,        0, 64'h0,    64'h3028, 1, 4'd15);
      // Sixteenth valid fetch wraps the 4-bit counter
      step(0,0,0,0,0,        1, 64'h3028, 64'h302C, 1, 4'd0);
      // PC wrap at the top of the address space
      step(0,0,0,1,64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 4'd0);
      step(0,0,0,0,0,        1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 4'd1);
      step(0,0,0,0,0,        1, 64'h0,    64'h4,    1, 4'd2);
      // Flush alone: bubble while the PC keeps advancing
      step(0,0,1,0,0,        0, 64'h0,    64'h8,    1, 4'd2);
      step(0,0,0,0,0,        1, 64'h8,    64'hC,    1, 4'd3);
      // Reset mid-stream, also overriding a simultaneous misaligned redirect
      step(1,0,0,1,64'h5001, 0, 64'h0,    64'h1000, 0, 4'd0);
      step(0,0,0,0,0,        1, 64'h1000, 64'h1004, 0, 4'd1);

      // Give the monitor a bounded window to drain the queue
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage of the pipelined processor: PC register, sequential next-PC adder, branch/jump redirect, stall and flush control, and the IF/ID pipeline register with a valid bit.
- Drives an external combinational instruction memory and hands the fetched instruction and its address to decode.
- Generalises the fixed 64-bit PC / 32-bit instruction fetch path: configurable widths, reset vector and NOP encoding, hazard control, a misalignment flag and a fetch performance counter.

Parameters:
- ADDR_WIDTH, 64, PC and instruction-address width.
- INST_WIDTH, 32, instruction width.
- INST_BYTES, 4, PC increment per sequential fetch; must be a power of two.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INST, 32'h00000013, bubble encoding written into IF/ID on flush or reset.
- CNT_WIDTH, 32, width of the fetch performance counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  instruction-memory address; combinationally equal to the PC.
- imem_data  input  INST_WIDTH  instruction returned combinationally for imem_addr.
- stall  input  1  hazard stall from decode: hold the PC and IF/ID.
- flush  input  1  squash the IF/ID contents, e.g. on an exception.
- redirect  input  1  taken branch or jump resolved this cycle.
- redirect_target  input  ADDR_WIDTH  new PC when redirect is high.
- instruction_out  output  INST_WIDTH  IF/ID instruction.
- inst_addr_out  output  ADDR_WIDTH  IF/ID instruction address.
- valid_out  output  1  IF/ID holds a real instruction.
- misalign_err  output  1  sticky: a misaligned redirect target was seen.
- fetch_count  output  CNT_WIDTH  number of valid instructions latched into IF/ID.

Behaviour:
- All state updates on the rising edge of clk; reset is sampled only at that edge.
- Reset values:
  - PC = RESET_PC
  - instruction_out = NOP_INST
  - inst_addr_out = 0
  - valid_out = 0
  - misalign_err = 0
  - fetch_count = 0
- Reset overrides every other input.
- PC next-state priority:
  1. reset
  2. redirect: PC <= redirect_target with the low log2(INST_BYTES) bits forced to 0
  3. stall: PC holds
  4. otherwise: PC <= PC + INST_BYTES, modulo 2^ADDR_WIDTH; wraps silently at the top of the address space.
- IF/ID next-state priority:
  1. reset
  2. redirect or flush: instruction_out <= NOP_INST, inst_addr_out <= 0, valid_out <= 0
  3. stall: hold all three
  4. otherwise: instruction_out <= imem_data, inst_addr_out <= PC, valid_out <= 1.
- Stall together with redirect: redirect wins for both the PC and IF/ID; the redirect is never lost.
- Stall together with flush (no redirect): IF/ID becomes a bubble and the PC holds.
- Timing:
  - Redirect asserted in cycle N: PC = target in cycle N+1; IF/ID is a bubble in cycle N+1; the target instruction is valid in IF/ID in cycle N+2.
  - Sequential fetch latency: 1 cycle from PC to IF/ID.
  - First valid IF/ID entry appears on the first edge after reset deasserts, with inst_addr_out = RESET_PC.
- misalign_err: set on any edge where redirect = 1 and redirect_target's low log2(INST_BYTES) bits are nonzero. Stays set until reset.
- fetch_count: increments by 1 on every edge where IF/ID loads with valid_out <= 1 (neither a stall hold nor a bubble counts). Wraps modulo 2^CNT_WIDTH.
- imem_addr is purely combinational from the PC register; no other combinational paths exist from inputs to outputs.

Test Plan:
1. Reset then run: reset high 2 cycles, RESET_PC=0x1000, imem returns address-derived data -> IF/ID addresses 0x1000, 0x1004, 0x1008 on successive edges; valid_out=1 from the first edge after reset; fetch_count=3 after 3 edges.
2. Stall: stall high for 3 cycles while IF/ID holds 0x1008 -> PC, instruction_out, inst_addr_out and fetch_count frozen; resumes at 0x100C after stall drops.
3. Redirect: redirect to 0x2000 in cycle N -> cycle N+1 instruction_out=0x00000013, valid_out=0, PC=0x2000; cycle N+2 inst_addr_out=0x2000, valid_out=1.
4. Redirect during stall plus misaligned target: stall=1, redirect=1, target 0x3002 -> PC=0x3000, IF/ID bubble, misalign_err=1 and still 1 after 10 further cycles; cleared only by reset.
5. Flush with stall: flush=1, stall=1 -> valid_out=0, PC unchanged, fetch_count unchanged.
6. Wrap cases:
   - PC at 2^ADDR_WIDTH-4 -> next PC is 0.
   - CNT_WIDTH=4: after 16 valid fetches, fetch_count=0.
   - Reset mid-stream -> all outputs return to their reset values on the same edge.
